// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter, per-channel slew-limited pulse width,
// valid/ready width commands and per-channel brake to neutral.

module servo_pwm_ch #(
  parameter int CNT_W         = 21,
  parameter int NEUTRAL_PULSE = 150_000,
  parameter int RAMP_STEP     = 2_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             boundary,
  input  logic [CNT_W-1:0] counter,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  input  logic             brake,
  output logic             pwm,
  output logic             at_target
);
  localparam logic [CNT_W-1:0] NEU  = CNT_W'(NEUTRAL_PULSE);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

  logic [CNT_W-1:0] active, target, t, diff, nxt;

  // Ramp toward the write-first target so a command landing on the boundary counts now.
  always_comb begin
    t    = wr ? wdata : target;
    nxt  = active;
    diff = '0;
    if (RAMP_STEP == 0) begin
      nxt = t;
    end else if (t > active) begin
      diff = t - active;
      nxt  = (diff > STEP) ? active + STEP : t;
    end else if (t < active) begin
      diff = active - t;
      nxt  = (diff > STEP) ? active - STEP : t;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= NEU;
      target <= NEU;
      pwm    <= 1'b0;
    end else begin
      pwm <= enable && (counter < active);
      if (boundary && brake) begin
        active <= NEU;
        target <= NEU;
      end else begin
        if (wr)       target <= wdata;
        if (boundary) active <= nxt;
      end
    end
  end

  assign at_target = (active == target);
endmodule

module servo_pwm_multi #(
  parameter int NUM_CH        = 2,
  parameter int CNT_W         = 21,
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int MIN_PULSE     = 100_000,
  parameter int MAX_PULSE     = 200_000,
  parameter int NEUTRAL_PULSE = 150_000,
  parameter int RAMP_STEP     = 2_000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]  cmd_width,
  input  logic [NUM_CH-1:0] brake,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start,
  output logic [NUM_CH-1:0] at_target,
  output logic              cmd_err
);
  localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MINP   = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAXP   = CNT_W'(MAX_PULSE);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_nch
    $fatal(1, "servo_pwm_multi: NUM_CH out of range");
  end
  if (!(MIN_PULSE <= NEUTRAL_PULSE && NEUTRAL_PULSE <= MAX_PULSE && MAX_PULSE < PERIOD_CYCLES)) begin : g_chk_pulse
    $fatal(1, "servo_pwm_multi: pulse limits inconsistent");
  end
  if ((longint'(PERIOD_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_cnt
    $fatal(1, "servo_pwm_multi: PERIOD_CYCLES does not fit CNT_W");
  end

  logic [CNT_W-1:0] counter, wdata;
  logic             boundary, accept, ch_bad;

  assign boundary = enable && (counter == PER_M1);
  assign accept   = cmd_valid && cmd_ready;
  assign wdata    = (cmd_width < MINP) ? MINP : (cmd_width > MAXP) ? MAXP : cmd_width;

  // A full power-of-two channel count cannot address a missing channel.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_bad = 1'b0;
  end else begin : g_ch_part
    localparam logic [CH_W-1:0] NCH_L = CH_W'(NUM_CH);
    assign ch_bad = (cmd_ch >= NCH_L);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter     <= '0;
      frame_start <= 1'b0;
      cmd_ready   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      if (!enable || counter == PER_M1) counter <= '0;
      else                              counter <= counter + CNT_W'(1);
      frame_start <= enable && (counter == '0);
      cmd_ready   <= 1'b1;
      cmd_err     <= accept && ch_bad;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_ch #(
      .CNT_W(CNT_W), .NEUTRAL_PULSE(NEUTRAL_PULSE), .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .boundary  (boundary),
      .counter   (counter),
      .wr        (accept && !ch_bad && (cmd_ch == CH_W'(i))),
      .wdata     (wdata),
      .brake     (brake[i]),
      .pwm       (pwm[i]),
      .at_target (at_target[i])
    );
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: frame-level literal expectations plus a
// per-cycle behavioural model of frame position, targets and slew-limited widths.

module tb_servo_pwm_multi;
  localparam int NCH = 2, CW = 12, PER = 1000, MINP = 50, MAXP = 100, NEU = 75, STEP = 10;

  logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, cmd_valid = 1'b0;
  logic [0:0]    cmd_ch = '0;
  logic [CW-1:0] cmd_width = '0;
  logic [1:0]    brake = '0;
  logic [1:0]    pwm, at_target;
  logic          frame_start, cmd_ready, cmd_err;

  logic          cmd_valid2 = 1'b0;
  logic [1:0]    cmd_ch2 = '0;
  logic [CW-1:0] cmd_width2 = '0;
  logic [2:0]    brake2 = '0;
  logic [2:0]    pwm2, at2;
  logic          fs2, rdy2, err2;

  int tests = 0, fails = 0;

  servo_pwm_multi #(.NUM_CH(NCH), .CNT_W(CW), .PERIOD_CYCLES(PER), .MIN_PULSE(MINP),
    .MAX_PULSE(MAXP), .NEUTRAL_PULSE(NEU), .RAMP_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_width(cmd_width), .brake(brake), .pwm(pwm),
    .frame_start(frame_start), .at_target(at_target), .cmd_err(cmd_err));

  // Three channels leave code 3 unmapped, so the error path is reachable here.
  servo_pwm_multi #(.NUM_CH(3), .CNT_W(CW), .PERIOD_CYCLES(PER), .MIN_PULSE(MINP),
    .MAX_PULSE(MAXP), .NEUTRAL_PULSE(NEU), .RAMP_STEP(STEP)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid2), .cmd_ready(rdy2),
    .cmd_ch(cmd_ch2), .cmd_width(cmd_width2), .brake(brake2), .pwm(pwm2),
    .frame_start(fs2), .at_target(at2), .cmd_err(err2));

  always #5 clk = ~clk;

  // Model state: position within the frame, per-channel active and target widths.
  int         m_pos;
  int         m_act [NCH];
  int         m_tgt [NCH];
  logic [1:0] e_pwm;
  logic       e_fs, e_rdy, e_err;

  always @(posedge clk) begin : model
    int na [NCH];
    int nt [NCH];
    int w;
    bit acc, bnd;
    if (reset) begin
      m_pos <= 0;
      for (int i = 0; i < NCH; i++) begin m_act[i] <= NEU; m_tgt[i] <= NEU; end
      e_pwm <= '0; e_fs <= 1'b0; e_rdy <= 1'b0; e_err <= 1'b0;
    end else begin
      acc = cmd_valid && e_rdy;
      bnd = enable && (m_pos == PER - 1);
      w = int'(cmd_width);
      if (w < MINP) w = MINP;
      if (w > MAXP) w = MAXP;
      for (int i = 0; i < NCH; i++) begin
        e_pwm[i] <= enable && (m_pos < m_act[i]);
        na[i] = m_act[i];
        nt[i] = m_tgt[i];
        if (bnd && brake[i]) begin
          na[i] = NEU; nt[i] = NEU;
        end else begin
          if (acc && int'(cmd_ch) == i) nt[i] = w;
          if (bnd) begin
            if (nt[i] - na[i] > STEP)      na[i] = na[i] + STEP;
            else if (na[i] - nt[i] > STEP) na[i] = na[i] - STEP;
            else                           na[i] = nt[i];
          end
        end
        m_act[i] <= na[i];
        m_tgt[i] <= nt[i];
      end
      e_fs  <= enable && (m_pos == 0);
      e_err <= acc && (int'(cmd_ch) >= NCH);
      e_rdy <= 1'b1;
      m_pos <= enable ? (m_pos + 1) % PER : 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] eat;
    for (int i = 0; i < NCH; i++) eat[i] = (m_act[i] == m_tgt[i]);
    tests++;
    if ({pwm, frame_start, cmd_ready, cmd_err, at_target} !== {e_pwm, e_fs, e_rdy, e_err, eat}) begin
      fails++;
      $display("FAIL model_cycle t=%0t: got pwm=%b fs=%b rdy=%b err=%b at=%b, expected pwm=%b fs=%b rdy=%b err=%b at=%b",
               $time, pwm, frame_start, cmd_ready, cmd_err, at_target, e_pwm, e_fs, e_rdy, e_err, eat);
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Measures one frame from a frame_start pulse up to the next one.
  task automatic frame(output int h0, output int h1, output int per,
                       output logic [1:0] at_s, output logic [1:0] first);
    int n;
    h0 = 0; h1 = 0; per = 0; at_s = '0; first = '0; n = 0;
    while (frame_start !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin chk("frame_start_timeout", 0, 1); return; end
    at_s = at_target;
    first = pwm;
    n = 0;
    do begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      n++;
      @(negedge clk);
    end while (frame_start !== 1'b1 && n < 3000);
    per = n;
  endtask

  // One frame with an optional command at a cycle offset and an optional boundary brake.
  task automatic step(string nm, bit c_en, int c_ch, int c_w, int c_off, logic [1:0] brk,
                      int e0, int e1, logic [1:0] e_at);
    int h0, h1, per;
    logic [1:0] at_s, first;
    fork
      frame(h0, h1, per, at_s, first);
      begin
        if (c_en) begin
          repeat (c_off) @(negedge clk);
          cmd_valid = 1'b1; cmd_ch = c_ch[0:0]; cmd_width = c_w[CW-1:0];
          @(negedge clk);
          cmd_valid = 1'b0;
        end
      end
      begin
        if (brk != 2'b00) begin
          repeat (998) @(negedge clk);
          brake = brk;
          @(negedge clk);
          brake = 2'b00;
        end
      end
    join
    chk({nm, "_h0"}, h0, e0);
    chk({nm, "_h1"}, h1, e1);
    chk({nm, "_period"}, per, PER);
    chk({nm, "_at_target"}, int'(at_s), int'(e_at));
    chk({nm, "_first_pwm"}, int'(first), 3);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_at_target", int'(at_target), 3);
    chk("rst_frame_start", int'(frame_start), 0);
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", int'(cmd_ready), 1);

    // Out-of-range channel on the 3-channel instance, then an in-range one.
    cmd_valid2 = 1'b1; cmd_ch2 = 2'd3; cmd_width2 = 12'd60;
    @(negedge clk);
    chk("err_pulse", int'(err2), 1);
    chk("err_targets_kept", int'(at2), 7);
    cmd_ch2 = 2'd2; cmd_width2 = 12'd100;
    @(negedge clk);
    chk("err_one_cycle", int'(err2), 0);
    chk("ch2_target_set", int'(at2), 3);
    cmd_valid2 = 1'b0;

    step("s1_idle",     0, 0, 0,    0,   2'b00, 75,  75,  2'b11);
    step("s2_cmd100",   1, 0, 100,  300, 2'b00, 75,  75,  2'b11);
    step("s3_ramp85",   0, 0, 0,    0,   2'b00, 85,  75,  2'b10);
    step("s4_ramp95",   0, 0, 0,    0,   2'b00, 95,  75,  2'b10);
    step("s5_reach100", 0, 0, 0,    0,   2'b00, 100, 75,  2'b11);
    step("s6_hold100",  0, 0, 0,    0,   2'b00, 100, 75,  2'b11);
    step("s7_ch1_lo",   1, 1, 10,   300, 2'b00, 100, 75,  2'b11);
    step("s8_ch1_hi",   1, 1, 4000, 300, 2'b00, 100, 65,  2'b01);
    step("s9",          0, 0, 0,    0,   2'b00, 100, 75,  2'b01);
    step("s10",         0, 0, 0,    0,   2'b00, 100, 85,  2'b01);
    step("s11",         0, 0, 0,    0,   2'b00, 100, 95,  2'b01);
    step("s12_brake0",  0, 0, 0,    0,   2'b01, 100, 100, 2'b11);
    step("s13_cmd100",  1, 0, 100,  300, 2'b00, 75,  100, 2'b11);
    step("s14_brk_cmd", 1, 0, 60,   998, 2'b01, 85,  100, 2'b10);
    step("s15_neutral", 0, 0, 0,    0,   2'b00, 75,  100, 2'b11);
    step("s16_neutral", 0, 0, 0,    0,   2'b00, 75,  100, 2'b11);

    // Drop enable mid-pulse, stay quiet, then restart.
    repeat (30) @(negedge clk);
    chk("pre_disable_pwm", int'(pwm), 3);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_pwm_off", int'(pwm), 0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (pwm !== 2'b00 || frame_start !== 1'b0) bad++;
    end
    chk("disable_quiet", bad, 0);
    enable = 1'b1;
    step("s17_restart", 0, 0, 0,    0,   2'b00, 75,  100, 2'b11);
    step("s18_cmd100",  1, 0, 100,  300, 2'b00, 75,  100, 2'b11);
    step("s19_ramp85",  0, 0, 0,    0,   2'b00, 85,  100, 2'b10);

    // Reset mid-pulse while ch0 is at 95; a command during reset must be ignored.
    repeat (20) @(negedge clk);
    chk("pre_reset_pwm", int'(pwm), 3);
    reset = 1'b1; cmd_valid = 1'b1; cmd_ch = 1'b1; cmd_width = 12'd100;
    @(negedge clk);
    chk("midrst_pwm", int'(pwm), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 0);
    chk("midrst_at_target", int'(at_target), 3);
    reset = 1'b0; cmd_valid = 1'b0;
    step("s21_post_rst", 0, 0, 0, 0, 2'b00, 75, 75, 2'b11);
    step("s22_post_rst", 0, 0, 0, 0, 2'b00, 75, 75, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Multi-channel servo PWM generator for the robot drive and actuator servos.
- Contains its own free-running frame counter and accepts per-channel pulse-width commands over a valid/ready port.
- Limits each channel's pulse-width change to a fixed step per frame and provides a per-channel brake to neutral.
- Replaces per-servo fixed-width controllers fed from a shared external counter.

Parameters:
- NUM_CH, 2, number of independent PWM channels (1..8).
- CNT_W, 21, width of the frame counter and pulse-width values.
- PERIOD_CYCLES, 2_000_000, frame length in clk cycles (20 ms at 100 MHz).
- MIN_PULSE, 100_000, minimum legal pulse width in cycles (1.0 ms).
- MAX_PULSE, 200_000, maximum legal pulse width in cycles (2.0 ms).
- NEUTRAL_PULSE, 150_000, brake/reset pulse width in cycles (1.5 ms).
- RAMP_STEP, 2_000, maximum change of active width per frame; 0 means jump directly to target.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global output enable
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_ch  in  max(1,$clog2(NUM_CH))  target channel index
- cmd_width  in  CNT_W  requested pulse width in cycles
- brake  in  NUM_CH  per-channel brake request (level)
- pwm  out  NUM_CH  servo pulse outputs
- frame_start  out  1  one-cycle pulse at frame start
- at_target  out  NUM_CH  high when channel active width equals target
- cmd_err  out  1  one-cycle pulse on accepted command with cmd_ch >= NUM_CH

Behaviour:
- Reset (synchronous, active-high):
  - counter=0, every active[i]=target[i]=NEUTRAL_PULSE.
  - pwm=0, frame_start=0, cmd_err=0, cmd_ready=0.
  - at_target=all ones.
- Registered outputs: cmd_ready is registered and is 1 from the first cycle after reset deasserts. A command presented in the same cycle as reset is ignored.
- Frame counter:
  - While enable=1, counts 0..PERIOD_CYCLES-1 and wraps to 0.
  - While enable=0, the counter is held at 0.
  - The boundary cycle is counter==PERIOD_CYCLES-1 with enable=1.
- frame_start is registered: it is 1 in the cycle after the counter holds 0 with enable=1, i.e. aligned with the first high cycle of pwm.
- pwm[i] timing:
  - pwm[i] is registered: pwm[i] <= enable & (counter < active[i]).
  - Output latency is 1 cycle, and the high time per frame is exactly active[i] cycles.
  - When enable falls, pwm goes to 0 the next cycle.
- Command accept:
  - On cmd_valid & cmd_ready, the width is clamped to [MIN_PULSE, MAX_PULSE] and written to target[cmd_ch].
  - If cmd_ch >= NUM_CH, the command is dropped and cmd_err pulses for 1 cycle.
  - The command is accepted in any cycle; active widths change only at boundaries.
- Boundary update (per channel, on the boundary cycle; new active value is used from counter==0):
  - brake[i]=1: active[i] and target[i] are set to NEUTRAL_PULSE with no ramp. A same-cycle command to channel i is discarded (no error).
  - Otherwise, with t = target value including any command accepted this same cycle (write-first):
    - RAMP_STEP=0: active[i] = t.
    - t > active[i]: active[i] += min(RAMP_STEP, t - active[i]).
    - t < active[i]: active[i] -= min(RAMP_STEP, active[i] - t).
- Arithmetic: unsigned CNT_W; differences are computed without overflow because MIN_PULSE <= widths <= MAX_PULSE.
- Elaboration checks (fatal on failure):
  - MIN_PULSE <= NEUTRAL_PULSE <= MAX_PULSE < PERIOD_CYCLES.
  - PERIOD_CYCLES-1 fits in CNT_W.
- at_target[i] is combinational: active[i]==target[i].
- Reset mid-frame: all state returns to reset values next cycle; pwm drops to 0 immediately after the reset cycle.

Test Plan:
Bench parameters: NUM_CH=2, CNT_W=12, PERIOD_CYCLES=1000, MIN_PULSE=50, MAX_PULSE=100, NEUTRAL_PULSE=75, RAMP_STEP=10.
1. Release reset, enable=1, no commands -> frame_start every 1000 cycles; pwm[0], pwm[1] high exactly 75 cycles, starting on the same cycle as frame_start; at_target=2'b11.
2. cmd ch0 width 100 mid-frame -> ch0 high times over successive frames are 75 (current frame), then 85, 95, 100, 100; at_target[0] rises once active reaches 100; ch1 stays 75.
3. cmd ch1 width 10, then width 4000 -> clamped targets 50 and 100 respectively; cmd ch 3 -> dropped, cmd_err 1-cycle pulse, targets unchanged.
4. ch0 ramping toward 100 while at 85, brake[0]=1 on a boundary together with cmd ch0 width 60 -> next frame ch0 high 75 cycles, target stays 75; brake does not affect ch1.
5. enable low mid-pulse -> pwm 0 next cycle, no frame_start; enable high again -> counter restarts at 0, full pulse in the first frame.
6. reset asserted mid-frame with ch0 active at 95 -> next cycle pwm=0 and cmd_ready=0; after release, pulses are 75 cycles and at_target=2'b11.
